// File: rtl/tx_sched_pkg.sv
// Shared types and sizing helpers for the photonic transmitter scheduler.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Counter only needs to hold values up to max(slot, gap) - 1; never narrower than 1 bit.
    function automatic int cnt_width(input int slot_cycles, input int gap_cycles);
        int m;
        m = 1;
        if (slot_cycles > m) m = slot_cycles;
        if (gap_cycles > m) m = gap_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/tx_scheduler_if.sv
// Requester-side request/ack bundle plus the transmitter drive signals.
interface tx_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ID_WIDTH-1:0]   req_dest;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [ID_WIDTH-1:0]           tx_dest_id;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic [ID_WIDTH-1:0]           tx_src_id;
    logic                          tx_enable;
    logic                          busy;

    modport master (
        output req, req_dest, req_data,
        input  ack, tx_dest_id, tx_data, tx_src_id, tx_enable, busy
    );

    modport slave (
        input  req, req_dest, req_data,
        output ack, tx_dest_id, tx_data, tx_src_id, tx_enable, busy
    );
endinterface

// File: rtl/tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        any_req   = |req;
        // Scan farthest offset first so the nearest asserted request overwrites and wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/tx_scheduler.sv
// Round-robin sharing of one photonic transmitter: fixed-length slot per packet, then a guard gap.
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int SLOT_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    tx_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CW    = cnt_width(SLOT_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IDX_W-1:0]       ptr, ptr_n;
    logic [NUM_REQ-1:0]     ack_n;
    logic                   en_n, busy_n, arbitrate;
    logic [ID_WIDTH-1:0]    dest_n, src_n;
    logic [DATA_WIDTH-1:0]  data_n;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any_req;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req       (bus.req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        ack_n     = '0;
        en_n      = bus.tx_enable;
        dest_n    = bus.tx_dest_id;
        data_n    = bus.tx_data;
        src_n     = bus.tx_src_id;
        // The last guard cycle arbitrates so a new slot starts right as the gap expires.
        arbitrate = (state == IDLE) || ((state == GAP) && (cnt == '0));
        if (arbitrate && any_req) begin
            state_n = SEND;
            cnt_n   = SLOT_LAST;
            en_n    = 1'b1;
            dest_n  = bus.req_dest[int'(grant_idx)*ID_WIDTH +: ID_WIDTH];
            data_n  = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            src_n   = ID_WIDTH'(grant_idx);
            if (SLOT_CYCLES == 1) ack_n = grant;
        end else begin
            case (state)
                IDLE: ;
                SEND: begin
                    if (cnt == '0) begin
                        ptr_n  = IDX_W'((int'(bus.tx_src_id) + 1) % NUM_REQ);
                        en_n   = 1'b0;
                        dest_n = '0;
                        data_n = '0;
                        src_n  = '0;
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                            cnt_n   = GAP_LAST;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt - CW'(1);
                        // Registered ack lands on the cycle where the counter reads zero.
                        if (cnt == CW'(1)) ack_n = NUM_REQ'(1) << bus.tx_src_id;
                    end
                end
                GAP: begin
                    if (cnt == '0) state_n = IDLE;
                    else           cnt_n   = cnt - CW'(1);
                end
                default: state_n = IDLE;
            endcase
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ptr            <= '0;
            bus.ack        <= '0;
            bus.tx_enable  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.tx_dest_id <= '0;
            bus.tx_data    <= '0;
            bus.tx_src_id  <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            ptr            <= ptr_n;
            bus.ack        <= ack_n;
            bus.tx_enable  <= en_n;
            bus.busy       <= busy_n;
            bus.tx_dest_id <= dest_n;
            bus.tx_data    <= data_n;
            bus.tx_src_id  <= src_n;
        end
    end
endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench: dut_a uses the default build (GAP 1), dut_b a GAP_CYCLES=0 build.
module tb_tx_scheduler;
    localparam int NR = 4, IW = 2, DW = 8, SLOT = 2;

    typedef struct packed {
        logic [IW-1:0] src;
        logic [IW-1:0] dest;
        logic [DW-1:0] data;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_v  [2];
    logic [NR*IW-1:0] dest_v [2];
    logic [NR*DW-1:0] data_v [2];
    logic [NR-1:0]    ack_w  [2];
    logic             en_w   [2];
    logic             busy_w [2];
    logic [IW-1:0]    dst_w  [2];
    logic [IW-1:0]    src_w  [2];
    logic [DW-1:0]    dat_w  [2];

    tx_scheduler_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW)) ia ();
    tx_scheduler_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW)) ib ();

    assign ia.req = req_v[0];  assign ia.req_dest = dest_v[0];  assign ia.req_data = data_v[0];
    assign ib.req = req_v[1];  assign ib.req_dest = dest_v[1];  assign ib.req_data = data_v[1];
    assign ack_w[0] = ia.ack;  assign en_w[0] = ia.tx_enable;   assign busy_w[0] = ia.busy;
    assign dst_w[0] = ia.tx_dest_id; assign src_w[0] = ia.tx_src_id; assign dat_w[0] = ia.tx_data;
    assign ack_w[1] = ib.ack;  assign en_w[1] = ib.tx_enable;   assign busy_w[1] = ib.busy;
    assign dst_w[1] = ib.tx_dest_id; assign src_w[1] = ib.tx_src_id; assign dat_w[1] = ib.tx_data;

    tx_scheduler #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW), .SLOT_CYCLES(SLOT), .GAP_CYCLES(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    tx_scheduler #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW), .SLOT_CYCLES(SLOT), .GAP_CYCLES(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    pkt_t q0[$];
    pkt_t q1[$];
    int   pend [2][NR];
    int   ack_cyc [16];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input pkt_t p);
        if (d == 0) q0.push_back(p);
        else        q1.push_back(p);
    endtask

    task automatic issue(input int d, input int i, input logic [IW-1:0] dest, input logic [DW-1:0] data);
        pkt_t p;
        dest_v[d][i*IW +: IW] = dest;
        data_v[d][i*DW +: DW] = data;
        req_v[d][i] = 1'b1;
        pend[d][i]++;
        p.src  = IW'(i);
        p.dest = dest;
        p.data = data;
        push(d, p);
    endtask

    // Acts as the requesters: drops req once each has seen the acks it is owed.
    task automatic run(input int d, input bit mutate, output int n_ack, output int busy_cnt);
        bit done, mut;
        int left;
        n_ack = 0; busy_cnt = 0; done = 1'b0; mut = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (busy_w[d]) busy_cnt++;
            if (mutate && en_w[d] && !mut) begin
                data_v[d][DW-1:0] = 8'hFF;
                mut = 1'b1;
            end
            for (int i = 0; i < NR; i++) begin
                if (ack_w[d][i]) begin
                    if (n_ack < 16) ack_cyc[n_ack] = k;
                    n_ack++;
                    if (pend[d][i] > 0) pend[d][i]--;
                    if (pend[d][i] == 0) req_v[d][i] = 1'b0;
                end
            end
            left = 0;
            for (int i = 0; i < NR; i++) left += pend[d][i];
            done = !busy_w[d] && (left == 0);
        end
        if (!done) check("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic monitor();
        logic prev [2];
        int   cnt  [2];
        pkt_t cur  [2];
        pkt_t a, e;
        for (int d = 0; d < 2; d++) begin prev[d] = 1'b0; cnt[d] = 0; cur[d] = '0; end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                a.src = src_w[d]; a.dest = dst_w[d]; a.data = dat_w[d];
                if (!rst_n) begin
                    prev[d] = 1'b0;
                    cnt[d]  = 0;
                end else begin
                    if (en_w[d] && !prev[d]) begin
                        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                            check("unexpected_tx", 32'(a), 32'hFFFF_FFFF);
                        end else begin
                            if (d == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            check("pkt", 32'(a), 32'(e));
                            cur[d] = e;
                        end
                        cnt[d] = 1;
                    end else if (en_w[d]) begin
                        cnt[d]++;
                        check("stable", 32'(a), 32'(cur[d]));
                    end else if (prev[d]) begin
                        check("slot_len", 32'(cnt[d]), 32'(SLOT));
                        check("idle_out", 32'(a), 32'd0);
                    end
                    if (ack_w[d] != '0)
                        check("ack", 32'({ack_w[d], en_w[d], cnt[d] == SLOT}),
                              32'({NR'(1) << cur[d].src, 1'b1, 1'b1}));
                    prev[d] = en_w[d];
                end
            end
        end
    endtask

    initial begin
        int   na, nb;
        pkt_t p;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = '0; dest_v[d] = '0; data_v[d] = '0;
            for (int i = 0; i < NR; i++) pend[d][i] = 0;
        end
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a", 32'({ack_w[0], en_w[0], busy_w[0], dst_w[0], dat_w[0], src_w[0]}), 32'd0);
        check("reset_b", 32'({ack_w[1], en_w[1], busy_w[1], dst_w[1], dat_w[1], src_w[1]}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All requesting from pointer 0: expect 0,1,2,3,0 spaced 3 cycles
        issue(0, 0, 2'd1, 8'h10);
        issue(0, 1, 2'd2, 8'h21);
        issue(0, 2, 2'd3, 8'h32);
        issue(0, 3, 2'd0, 8'h43);
        issue(0, 0, 2'd1, 8'h10);
        run(0, 1'b0, na, nb);
        check("all_n_ack", 32'(na), 32'd5);
        for (int j = 1; j < 5; j++) check("all_spacing", 32'(ack_cyc[j] - ack_cyc[j-1]), 32'd3);

        // Single request from requester 1
        issue(0, 1, 2'd3, 8'hA5);
        run(0, 1'b0, na, nb);
        check("single_n_ack", 32'(na), 32'd1);
        check("single_busy", 32'(nb), 32'd3);

        // Reset mid-SEND for requester 2 aborts without ack, then re-grant
        issue(0, 2, 2'd1, 8'h3C);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (en_w[0]) break;
        end
        check("abort_seen", 32'(en_w[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'({ack_w[0], en_w[0], busy_w[0], dst_w[0], dat_w[0], src_w[0]}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_ack", 32'(ack_w[0]), 32'd0);
        end
        p.src = 2'd2; p.dest = 2'd1; p.data = 8'h3C;
        push(0, p);
        rst_n = 1'b1;
        run(0, 1'b0, na, nb);
        check("regrant_n_ack", 32'(na), 32'd1);

        // Pointer now 3; req 0101 -> grant 0 then 2
        issue(0, 0, 2'd2, 8'h5A);
        issue(0, 2, 2'd0, 8'hC3);
        run(0, 1'b0, na, nb);
        check("wrap_n_ack", 32'(na), 32'd2);
        check("wrap_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

        // Payload changed during SEND must not reach the transmitter
        issue(0, 0, 2'd1, 8'h11);
        run(0, 1'b1, na, nb);
        check("stab_n_ack", 32'(na), 32'd1);

        // GAP_CYCLES=0 build: back-to-back 0 then 1 with one idle cycle between
        issue(1, 0, 2'd3, 8'h66);
        issue(1, 1, 2'd2, 8'h77);
        run(1, 1'b0, na, nb);
        check("nogap_n_ack", 32'(na), 32'd2);
        check("nogap_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        check("nogap_busy", 32'(nb), 32'd4);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
